mem_wait_if: RTL and testbench
==============================

// Module: mem_wait_if
// PURPOSE
//  Unified instruction/data memory port for the multi-cycle MIPS, fed directly by the datapath
//  (IorD-muxed address, B-register write data) and by the controller's MemRead/MemWrite strobes.
//  Models a slow memory with a programmable number of wait states. Returns read data plus a
//  one-cycle ready pulse, and drives a stall back to the controller FSM, which holds its state
//  until ready. Replaces the zero-latency memory in the datapath.
// PARAMETERS
//  DATA_W       32   data/address width
//  MEM_WORDS    256  words in the backing array; word index = addr[log2(MEM_WORDS)+1:2]
//  WAIT_STATES  2    cycles spent in BUSY before the access completes (0 allowed)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-low (0 = reset)
//  mem_read   in   1       read request level from controller (MemRead)
//  mem_write  in   1       write request level from controller (MemWrite)
//  addr       in   DATA_W  byte address from IorD mux
//  wdata      in   DATA_W  write data (B register)
//  rdata      out  DATA_W  registered read data, held until next completed read
//  ready      out  1       one-cycle pulse: access complete
//  stall      out  1       request accepted/in flight, controller must hold its state
//  addr_err   out  1       pulses with ready if the latched addr[1:0] != 0
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, cnt=0, rdata=0, ready=0, stall=0, addr_err=0.
//   The array is not cleared. A write in flight is aborted and never committed.
//  FSM states are IDLE, BUSY and DONE.
//   IDLE: if mem_write|mem_read is high, latch addr, wdata and op, and set cnt=WAIT_STATES.
//    Go to BUSY if WAIT_STATES>0, otherwise perform the access and go to DONE.
//    If both strobes are high, the write wins and the read is dropped.
//   BUSY: cnt decrements each cycle. When cnt==1, perform the access and go to DONE.
//   DONE: ready=1 for exactly this cycle, then return to IDLE. Requests are ignored in this
//    cycle, because the controller still presents the old strobe. A new request is accepted
//    in the following IDLE cycle (one bubble between accesses).
//  Access rules:
//   - A write commits to the array on the edge entering DONE. A read loads rdata on the same edge.
//   - Latency: request high at edge N gives ready high in the cycle after edge N+WAIT_STATES+1.
//   - rdata is unchanged by writes.
//  stall is combinational: (state==IDLE & (mem_read|mem_write)) | state==BUSY. It is 0 in DONE.
//  Address handling:
//   - Misaligned address: the access uses the aligned word (addr[1:0] ignored). addr_err=1 with ready.
//   - Address beyond the array: the word index wraps modulo MEM_WORDS. No error is flagged.
//  Strobe changes after acceptance (IDLE->BUSY) are ignored. The latched op and addr are used.
// STRUCTURE
//  mem_defs.vh (shared include): state encodings ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2,
//   default WAIT_STATES, MEM_WORDS.
//  Sub-module mem_array: MEM_WORDS x DATA_W storage with synchronous write enable and
//   combinational read by index. mem_wait_if holds the FSM, counter, latches and rdata register.
//  Top level: the controller's next-state logic gates on stall. The datapath's MDR loads on ready.
// TESTING
//  1. Reset mid-write: WAIT_STATES=2, write 0xDEADBEEF@0x10, drop reset in BUSY -> all outputs 0;
//     a later read@0x10 returns the prior contents, not 0xDEADBEEF.
//  2. Write then read: WAIT_STATES=2, write 0x12345678@0x20, then read@0x20 -> rdata=0x12345678.
//     ready arrives 3 cycles after each request edge. stall is high for 3 cycles per access.
//  3. WAIT_STATES=0: read@0x04 -> ready in the next cycle. stall is high 1 cycle.
//     A held mem_read yields exactly one access per IDLE acceptance.
//  4. Simultaneous mem_read & mem_write@0x08, wdata=0xA5A5A5A5 -> write performed.
//     rdata is unchanged, and a later read returns 0xA5A5A5A5.
//  5. Misaligned and wrap: read@0x22 -> word 0x20 data, addr_err=1 with ready.
//     MEM_WORDS=256, write@0x400 then read@0x0 -> same data.
//  6. Strobe dropped mid-BUSY: assert mem_read 1 cycle only -> access still completes,
//     ready pulses once, and no second access follows.

Source files
------------

// File: rtl/mem_wait_if_pkg.sv
// Shared definitions for the wait-state memory port: FSM encodings and default geometry.
package mem_wait_if_pkg;

    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_MEM_WORDS   = 256;
    localparam int unsigned DEF_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width able to hold WAIT_STATES, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_states);
        return (wait_states < 2) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/mem_wait_if_mem_array.sv
// Backing store: synchronous write, combinational read, single shared word index.
module mem_array
    import mem_wait_if_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    // Contents are deliberately not reset; they survive a port reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/mem_wait_if.sv
// Multi-cycle memory port with programmable wait states; stalls the controller until ready.
module mem_wait_if
    import mem_wait_if_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS,
    parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              addr_err
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = cnt_width(WAIT_STATES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               mis_q, mis_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               addr_err_q, addr_err_d;

    logic               req_c;
    logic [IDX_W-1:0]   req_idx_c;
    logic               req_mis_c;
    logic               commit_c;
    logic               cur_we_c;
    logic [IDX_W-1:0]   cur_idx_c;
    logic [DATA_W-1:0]  cur_wdata_c;
    logic               cur_mis_c;
    logic               mem_we_c;
    logic [DATA_W-1:0]  arr_rdata_c;
    logic               stall_c;
    logic               unused_addr_c;

    assign req_c         = mem_read | mem_write;
    assign req_idx_c     = addr[IDX_W+1:2];
    assign req_mis_c     = |addr[1:0];
    assign unused_addr_c = ^addr[DATA_W-1:IDX_W+2];

    // Access decode: with zero wait states the access is performed straight from the inputs.
    always_comb begin
        commit_c    = 1'b0;
        cur_we_c    = we_q;
        cur_idx_c   = idx_q;
        cur_wdata_c = wdata_q;
        cur_mis_c   = mis_q;
        stall_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_c = req_c;
                if (req_c && (WAIT_STATES == 0)) begin
                    commit_c    = 1'b1;
                    cur_we_c    = mem_write;
                    cur_idx_c   = req_idx_c;
                    cur_wdata_c = wdata;
                    cur_mis_c   = req_mis_c;
                end
            end
            ST_BUSY: begin
                stall_c  = 1'b1;
                commit_c = (cnt_q == CNT_W'(1));
            end
            default: ;
        endcase
    end

    assign mem_we_c = commit_c & cur_we_c;

    mem_array #(
        .DATA_W    (DATA_W),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we_c),
        .idx   (cur_idx_c),
        .wdata (cur_wdata_c),
        .rdata (arr_rdata_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        mis_d      = mis_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        addr_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    idx_d   = req_idx_c;
                    wdata_d = wdata;
                    we_d    = mem_write;
                    mis_d   = req_mis_c;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (commit_c) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Controller still shows the old strobe here, so nothing is accepted.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (commit_c) begin
            ready_d    = 1'b1;
            addr_err_d = cur_mis_c;
            if (!cur_we_c) begin
                rdata_d = arr_rdata_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            mis_q      <= mis_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign addr_err = addr_err_q;
    assign stall    = stall_c;

endmodule

// File: tb/tb_mem_wait_if.sv
// Directed bench for mem_wait_if: one instance with two wait states, one with none.
module tb_mem_wait_if;

    logic        clk;
    logic        reset;

    logic        r2_read, r2_write;
    logic [31:0] r2_addr, r2_wdata;
    logic [31:0] d2_rdata;
    logic        d2_ready, d2_stall, d2_err;

    logic        r0_read, r0_write;
    logic [31:0] r0_addr, r0_wdata;
    logic [31:0] d0_rdata;
    logic        d0_ready, d0_stall, d0_err;

    int n_cmp = 0;
    int n_bad = 0;

    mem_wait_if #(.DATA_W(32), .MEM_WORDS(256), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .mem_read(r2_read), .mem_write(r2_write),
        .addr(r2_addr), .wdata(r2_wdata), .rdata(d2_rdata), .ready(d2_ready),
        .stall(d2_stall), .addr_err(d2_err)
    );

    mem_wait_if #(.DATA_W(32), .MEM_WORDS(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_read(r0_read), .mem_write(r0_write),
        .addr(r0_addr), .wdata(r0_wdata), .rdata(d0_rdata), .ready(d0_ready),
        .stall(d0_stall), .addr_err(d0_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel0, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel0) begin
            r0_write = w; r0_read = r; r0_addr = a; r0_wdata = d;
        end else begin
            r2_write = w; r2_read = r; r2_addr = a; r2_wdata = d;
        end
    endtask

    // Presents a request, holds strobes for 'hold' edges or until ready, reports timing.
    task automatic run_access(input bit sel0, input logic w, input logic r,
                              input logic [31:0] a, input logic [31:0] d, input int hold,
                              output int lat, output int stc,
                              output logic [31:0] rd, output logic err);
        logic stl, rdy;
        drive(sel0, w, r, a, d);
        lat = 99; stc = 0; rd = 'x; err = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            #4;
            stl = sel0 ? d0_stall : d2_stall;
            if (stl) stc++;
            @(posedge clk); #1;
            if (i >= hold) drive(sel0, 1'b0, 1'b0, a, d);
            rdy = sel0 ? d0_ready : d2_ready;
            if (rdy) begin
                lat = i;
                rd  = sel0 ? d0_rdata : d2_rdata;
                err = sel0 ? d0_err : d2_err;
                drive(sel0, 1'b0, 1'b0, a, d);
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (d2_rdata !== 32'h0 || d2_ready !== 1'b0 || d2_stall !== 1'b0 || d2_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_d2: rdata=%h ready=%b stall=%b err=%b, want all 0", d2_rdata, d2_ready, d2_stall, d2_err);
        end
        n_cmp++; if (d0_rdata !== 32'h0 || d0_ready !== 1'b0 || d0_stall !== 1'b0 || d0_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_d0: rdata=%h ready=%b stall=%b err=%b, want all 0", d0_rdata, d0_ready, d0_stall, d0_err);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat, stc; logic [31:0] rd; logic err;
        run_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h1111_1111, 100, lat, stc, rd, err);
        @(posedge clk); #1;
        run_access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (rd !== 32'h1111_1111) begin
            n_bad++; $display("FAIL pre_reset_read: got %h want 11111111", rd);
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk); #2;
        n_cmp++; if (d2_stall !== 1'b1) begin
            n_bad++; $display("FAIL busy_before_reset: stall=%b want 1", d2_stall);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++; if (d2_rdata !== 32'h0 || d2_ready !== 1'b0 || d2_stall !== 1'b0 || d2_err !== 1'b0) begin
            n_bad++; $display("FAIL midwrite_reset_outs: rdata=%h ready=%b stall=%b err=%b, want all 0", d2_rdata, d2_ready, d2_stall, d2_err);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_access(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (rd !== 32'h1111_1111) begin
            n_bad++; $display("FAIL aborted_write_not_committed: got %h want 11111111", rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read;
        int lat, stc; logic [31:0] rd; logic err;
        run_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h1234_5678, 100, lat, stc, rd, err);
        n_cmp++; if (lat !== 3 || stc !== 3) begin
            n_bad++; $display("FAIL write_timing: lat=%0d stall_cycles=%0d want 3/3", lat, stc);
        end
        @(posedge clk); #1;
        run_access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (lat !== 3 || stc !== 3) begin
            n_bad++; $display("FAIL read_timing: lat=%0d stall_cycles=%0d want 3/3", lat, stc);
        end
        n_cmp++; if (rd !== 32'h1234_5678 || err !== 1'b0) begin
            n_bad++; $display("FAIL read_data: rdata=%h err=%b want 12345678/0", rd, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait;
        int lat, stc, nrdy; logic [31:0] rd; logic err;
        run_access(1'b1, 1'b1, 1'b0, 32'h04, 32'h0404_CAFE, 100, lat, stc, rd, err);
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 1'b1, 32'h04, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (lat !== 1 || stc !== 1) begin
            n_bad++; $display("FAIL ws0_timing: lat=%0d stall_cycles=%0d want 1/1", lat, stc);
        end
        n_cmp++; if (rd !== 32'h0404_CAFE) begin
            n_bad++; $display("FAIL ws0_read_data: got %h want 0404cafe", rd);
        end
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b1, 32'h04, 32'h0);
        nrdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (d0_ready) nrdy++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (d0_ready) nrdy++;
        end
        n_cmp++; if (nrdy !== 3) begin
            n_bad++; $display("FAIL ws0_held_read: ready pulses=%0d want 3", nrdy);
        end
    endtask

    task automatic test_both_strobes;
        int lat, stc; logic [31:0] rd; logic err;
        run_access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 100, lat, stc, rd, err);
        @(posedge clk); #1;
        run_access(1'b0, 1'b1, 1'b1, 32'h08, 32'hA5A5_A5A5, 100, lat, stc, rd, err);
        n_cmp++; if (lat !== 3 || rd !== 32'h1234_5678) begin
            n_bad++; $display("FAIL both_strobes_rdata_kept: lat=%0d rdata=%h want 3/12345678", lat, rd);
        end
        @(posedge clk); #1;
        run_access(1'b0, 1'b0, 1'b1, 32'h08, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (rd !== 32'hA5A5_A5A5) begin
            n_bad++; $display("FAIL both_strobes_write_won: got %h want a5a5a5a5", rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned_wrap;
        int lat, stc; logic [31:0] rd; logic err;
        run_access(1'b0, 1'b0, 1'b1, 32'h22, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (rd !== 32'h1234_5678 || err !== 1'b1) begin
            n_bad++; $display("FAIL misaligned_read: rdata=%h err=%b want 12345678/1", rd, err);
        end
        @(posedge clk); #1;
        n_cmp++; if (d2_err !== 1'b0) begin
            n_bad++; $display("FAIL addr_err_pulse: err=%b after ready, want 0", d2_err);
        end
        @(posedge clk); #1;
        run_access(1'b0, 1'b1, 1'b0, 32'h400, 32'hBEEF_0400, 100, lat, stc, rd, err);
        n_cmp++; if (err !== 1'b0) begin
            n_bad++; $display("FAIL wrap_no_err: err=%b want 0", err);
        end
        @(posedge clk); #1;
        run_access(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 100, lat, stc, rd, err);
        n_cmp++; if (rd !== 32'hBEEF_0400) begin
            n_bad++; $display("FAIL wrap_read: got %h want beef0400", rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_strobe_drop;
        int lat, stc, extra; logic [31:0] rd; logic err;
        run_access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 1, lat, stc, rd, err);
        n_cmp++; if (lat !== 3 || rd !== 32'h1234_5678) begin
            n_bad++; $display("FAIL strobe_drop_complete: lat=%0d rdata=%h want 3/12345678", lat, rd);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            #4;
            if (d2_stall) extra++;
            @(posedge clk); #1;
            if (d2_ready) extra++;
        end
        n_cmp++; if (extra !== 0) begin
            n_bad++; $display("FAIL strobe_drop_no_second: extra ready/stall cycles=%0d want 0", extra);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset_mid_write();
        test_write_read();
        test_zero_wait();
        test_both_strobes();
        test_misaligned_wrap();
        test_strobe_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
